// File: rtl/pci_initiator_pkg.sv
// Shared definitions for the PCI initiator: command codes, completion status
// codes, FSM state encoding and the request word-count normaliser.
package pci_initiator_pkg;

  localparam logic [3:0] PciCmdRead  = 4'b0010;
  localparam logic [3:0] PciCmdWrite = 4'b0011;

  typedef enum logic [1:0] {
    StatOk     = 2'b00,
    StatMabort = 2'b01,
    StatTabort = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StAbort
  } state_e;

  // A zero count still moves one word; anything beyond the burst limit is clipped.
  function automatic logic [2:0] norm_count(logic [2:0] count, int unsigned max_words);
    if (count == 3'd0) return 3'd1;
    if (32'(count) > max_words) return 3'(max_words);
    return count;
  endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// PCI bus signals between an initiator (master) and a target (slave).
//   frame_n, irdy_n : FRAME#, IRDY# driven by the initiator
//   cbe             : C/BE# (command in address phase, byte enables in data)
//   ad_out, ad_oe   : AD drive value and its output enable
//   ad_in           : sampled AD
//   devsel_n, trdy_n: DEVSEL#, TRDY# driven by the target
interface pci_initiator_if #(
  parameter int unsigned DATA_W = 32
);
  logic              frame_n;
  logic              irdy_n;
  logic [3:0]        cbe;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] ad_in;
  logic              devsel_n;
  logic              trdy_n;

  modport master (
    output frame_n, irdy_n, cbe, ad_out, ad_oe,
    input  ad_in, devsel_n, trdy_n
  );

  modport slave (
    input  frame_n, irdy_n, cbe, ad_out, ad_oe,
    output ad_in, devsel_n, trdy_n
  );
endinterface

// File: rtl/pci_initiator_devsel_timer.sv
// DEVSEL# watchdog for master-abort detection.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the count (address phase)
//   run      : count one edge (data phase with DEVSEL# not yet seen)
//   expire   : this edge is the TIMEOUT-th counted edge since load
module pci_initiator_devsel_timer #(
  parameter int unsigned TIMEOUT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(TIMEOUT);
    end else if (run && cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign expire = run && (cnt_q == CntW'(1));

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: takes one request (command, address, up to MAX_WORDS words)
// and runs a single burst read or write, then reports status and word count.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only while idle)
//   req_cmd/addr/count       : command, target address, word count
//   wr_data/wr_be            : write words and active-low byte enables, word0 lowest
//   rd_data                  : read words, same packing
//   done/status/xfer_cnt     : completion pulse, 00 ok / 01 master / 10 target abort,
//                              words actually moved
//   bus                      : PCI initiator-side bus signals
module pci_initiator
  import pci_initiator_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_WORDS      = 4,
  parameter int unsigned DEVSEL_TIMEOUT = 5,
  parameter logic [3:0]  PCI_READ       = PciCmdRead,
  parameter logic [3:0]  PCI_WRITE      = PciCmdWrite
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_cmd,
  input  logic [DATA_W-1:0]             req_addr,
  input  logic [2:0]                    req_count,
  input  logic [MAX_WORDS*DATA_W-1:0]   wr_data,
  input  logic [MAX_WORDS*4-1:0]        wr_be,
  output logic [MAX_WORDS*DATA_W-1:0]   rd_data,
  output logic                          done,
  output logic [1:0]                    status,
  output logic [2:0]                    xfer_cnt,
  pci_initiator_if.master               bus
);
  localparam int unsigned SelW = $clog2(MAX_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] addr_q;
  logic [2:0]        count_q, idx_q, xfer_q;
  logic [DATA_W-1:0] wdata_q [MAX_WORDS];
  logic [3:0]        be_q    [MAX_WORDS];
  logic [DATA_W-1:0] rd_q    [MAX_WORDS];
  logic              seen_q, done_q;
  status_e           status_q;

  logic            last, xfer, expire;
  logic [SelW-1:0] sel;

  assign sel  = idx_q[SelW-1:0];
  assign last = (idx_q == count_q - 3'd1);
  // IRDY# is always asserted in DATA, so a completed beat needs only the target side.
  assign xfer = ~bus.devsel_n & ~bus.trdy_n;

  pci_initiator_devsel_timer #(
    .TIMEOUT(DEVSEL_TIMEOUT)
  ) u_devsel_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == StAddr),
    .run   ((state_q == StData) && !seen_q),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StAddr;
      StAddr:  state_d = StData;
      StData: begin
        if (xfer && last) begin
          state_d = StIdle;
        end else if (bus.devsel_n && (seen_q || expire)) begin
          state_d = StAbort;
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    bus.frame_n = 1'b1;
    bus.irdy_n  = 1'b1;
    bus.cbe     = 4'hF;
    bus.ad_out  = '0;
    bus.ad_oe   = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StAddr: begin
        bus.frame_n = 1'b0;
        bus.ad_oe   = 1'b1;
        bus.ad_out  = addr_q;
        bus.cbe     = cmd_q;
      end
      StData: begin
        bus.irdy_n  = 1'b0;
        bus.frame_n = last;
        bus.cbe     = be_q[sel];
        if (cmd_q == PCI_WRITE) begin
          bus.ad_oe  = 1'b1;
          bus.ad_out = wdata_q[sel];
        end
      end
      StAbort: bus.irdy_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= 4'h0;
      addr_q   <= '0;
      count_q  <= 3'd1;
      idx_q    <= 3'd0;
      xfer_q   <= 3'd0;
      seen_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= StatOk;
      for (int i = 0; i < MAX_WORDS; i++) begin
        wdata_q[i] <= '0;
        be_q[i]    <= 4'hF;
        rd_q[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cmd_q    <= req_cmd;
            addr_q   <= req_addr;
            count_q  <= norm_count(req_count, MAX_WORDS);
            idx_q    <= 3'd0;
            xfer_q   <= 3'd0;
            seen_q   <= 1'b0;
            status_q <= StatOk;
            for (int i = 0; i < MAX_WORDS; i++) begin
              wdata_q[i] <= wr_data[DATA_W*i +: DATA_W];
              be_q[i]    <= wr_be[4*i +: 4];
            end
          end
        end
        StData: begin
          if (!bus.devsel_n) seen_q <= 1'b1;
          if (xfer) begin
            if (cmd_q == PCI_READ) rd_q[sel] <= bus.ad_in;
            idx_q  <= idx_q + 3'd1;
            xfer_q <= xfer_q + 3'd1;
            if (last) done_q <= 1'b1;
          end else if (state_d == StAbort) begin
            // DEVSEL# dropping after being claimed is the target's abort.
            status_q <= seen_q ? StatTabort : StatMabort;
          end
        end
        StAbort: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_WORDS; i++) begin
      rd_data[DATA_W*i +: DATA_W] = rd_q[i];
    end
  end

  assign done     = done_q;
  assign status   = status_q;
  assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_pci_initiator.sv
module tb_pci_initiator;
  localparam logic [3:0] RD = 4'b0010;
  localparam logic [3:0] WR = 4'b0011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_cmd = 4'h0;
  logic [31:0]  req_addr = 32'h0;
  logic [2:0]   req_count = 3'd0;
  logic [127:0] wr_data = '0;
  logic [15:0]  wr_be = '0;
  logic [127:0] rd_data;
  logic         done;
  logic [1:0]   status;
  logic [2:0]   xfer_cnt;

  always #5 clk = ~clk;

  pci_initiator_if #(.DATA_W(32)) bus ();

  pci_initiator #(
    .DATA_W        (32),
    .MAX_WORDS     (4),
    .DEVSEL_TIMEOUT(5),
    .PCI_READ      (4'b0010),
    .PCI_WRITE     (4'b0011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd  (req_cmd),
    .req_addr (req_addr),
    .req_count(req_count),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_data  (rd_data),
    .done     (done),
    .status   (status),
    .xfer_cnt (xfer_cnt),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   st;
    logic [2:0]   xc;
    logic [127:0] rd;
    int           done_cyc;
    bit           wr;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [31:0]  tgt_mem [16];
  logic [31:0]  ref_mem [16];
  logic [127:0] exp_rd = '0;

  // Intended transaction, shared with the target model for bus checks.
  logic [3:0]  cur_cmd = 4'h0;
  logic [31:0] cur_addr = 32'h0;
  int          cur_n = 1;
  logic [3:0]  cur_be [4];
  logic [31:0] cur_data [4];
  int          w_plan [4];
  int          abort_k = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Target model: claims addresses below 0x20, decides DEVSEL#/TRDY#/AD for the
  // coming edge from the bus values visible at the falling edge.
  initial begin
    bit active = 0;
    bit wr = 0;
    int beat = 0;
    int wl = 0;
    int base = 0;
    bus.devsel_n = 1'b1;
    bus.trdy_n   = 1'b1;
    bus.ad_in    = '0;
    forever begin
      @(negedge clk);
      bus.devsel_n = 1'b1;
      bus.trdy_n   = 1'b1;
      bus.ad_in    = $urandom;
      if (rst) begin
        active = 0;
      end else if (!bus.frame_n && bus.irdy_n) begin
        chk("addr_phase", {bus.ad_oe, bus.cbe, bus.ad_out}, {1'b1, cur_cmd, cur_addr});
        active = (bus.ad_out < 32'h20);
        base   = int'(bus.ad_out >> 2);
        wr     = (cur_cmd == WR);
        beat   = 0;
        wl     = w_plan[0];
      end else if (active && !bus.irdy_n) begin
        if (beat >= cur_n || base + beat >= 16) begin
          total++; bad++;
          $display("FAIL extra_beat: got beat %0d expected below %0d", beat, cur_n);
          active = 0;
        end else begin
          chk("data_phase_bus", {bus.frame_n, bus.cbe, bus.ad_oe, wr ? bus.ad_out : 32'h0},
              {(beat == cur_n - 1), cur_be[beat], wr, wr ? cur_data[beat] : 32'h0});
          if (beat == abort_k) begin
            active = 0;
          end else if (wl > 0) begin
            bus.devsel_n = 1'b0;
            wl--;
          end else begin
            bus.devsel_n = 1'b0;
            bus.trdy_n   = 1'b0;
            if (wr) begin
              for (int j = 0; j < 4; j++)
                if (!bus.cbe[j]) tgt_mem[base+beat][8*j +: 8] = bus.ad_out[8*j +: 8];
            end else begin
              bus.ad_in = tgt_mem[base+beat];
            end
            if (bus.frame_n) active = 0;
            beat++;
            if (beat < 4) wl = w_plan[beat];
          end
        end
      end else begin
        active = 0;
      end
    end
  end

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        bit ok;
        mon_e = sb_q.pop_front();
        chk("status", status, mon_e.st);
        chk("xfer_cnt", xfer_cnt, mon_e.xc);
        chk("rd_data", rd_data, mon_e.rd);
        chk("done_cycle", cyc, mon_e.done_cyc);
        if (mon_e.wr) begin
          ok = 1;
          for (int i = 0; i < 16; i++) if (tgt_mem[i] !== ref_mem[i]) ok = 0;
          chk("target_mem", ok, 1'b1);
        end
      end
    end
  end

  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input logic [2:0] cnt,
                         input logic [127:0] data, input logic [15:0] be,
                         input int w0, input int w1, input int w2, input int w3, input int ak);
    exp_t e;
    int n, lat, xc, t, idx;
    bit claim;
    n = (cnt == 3'd0) ? 1 : ((cnt > 3'd4) ? 4 : int'(cnt));
    claim = (addr < 32'h20);
    @(negedge clk);
    cur_cmd = cmd; cur_addr = addr; cur_n = n; abort_k = ak;
    w_plan[0] = w0; w_plan[1] = w1; w_plan[2] = w2; w_plan[3] = w3;
    for (int i = 0; i < 4; i++) begin
      cur_be[i]   = be[4*i +: 4];
      cur_data[i] = data[32*i +: 32];
    end
    if (!claim) begin
      e.st = 2'b01; xc = 0; lat = 1 + 5 + 1;
    end else if (ak >= 1 && ak < n) begin
      e.st = 2'b10; xc = ak; lat = 1 + 2;
      for (int i = 0; i < ak; i++) lat += w_plan[i] + 1;
    end else begin
      e.st = 2'b00; xc = n; lat = 1 + n;
      for (int i = 0; i < n; i++) lat += w_plan[i];
    end
    e.xc = 3'(xc);
    e.wr = (cmd == WR);
    for (int i = 0; i < xc; i++) begin
      idx = int'(addr >> 2) + i;
      if (e.wr) begin
        for (int b = 0; b < 4; b++)
          if (!be[4*i+b]) ref_mem[idx][8*b +: 8] = data[32*i+8*b +: 8];
      end else begin
        exp_rd[32*i +: 32] = ref_mem[idx];
      end
    end
    e.rd = exp_rd;
    e.done_cyc = cyc + 1 + lat;
    chk("req_ready_idle", req_ready, 1'b1);
    sb_q.push_back(e);
    req_cmd = cmd; req_addr = addr; req_count = cnt; wr_data = data; wr_be = be;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 1'b0);
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [2:0] c;
    logic [3:0] cm;
    logic [31:0] a;
    int n, ak;
    for (int i = 0; i < 16; i++) begin
      tgt_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      cur_be[i] = 4'h0; cur_data[i] = '0; w_plan[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_frame_n", bus.frame_n, 1'b1);
    chk("rst_irdy_n", bus.irdy_n, 1'b1);
    chk("rst_cbe", bus.cbe, 4'hF);
    chk("rst_ad_oe", bus.ad_oe, 1'b0);
    chk("rst_ad_out", bus.ad_out, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'b00);
    chk("rst_xfer_cnt", xfer_cnt, 3'd0);
    chk("rst_rd_data", rd_data, 128'h0);

    run_txn(WR, 32'h10, 3'd4, {32'h1004, 32'h1003, 32'h1002, 32'h1001}, 16'h0, 0, 0, 0, 0, -1);
    run_txn(RD, 32'h10, 3'd4, '0, 16'h0, 0, 0, 0, 0, -1);
    chk("read_back", rd_data, {32'h1004, 32'h1003, 32'h1002, 32'h1001});
    run_txn(WR, 32'h0, 3'd1, 128'hABCD, 16'h0, 0, 0, 0, 0, -1);
    run_txn(RD, 32'h20, 3'd4, '0, 16'h0, 0, 0, 0, 0, -1);
    run_txn(WR, 32'h0, 3'd4, {32'h4, 32'h3, 32'h2, 32'h1}, 16'h0, 0, 2, 0, 0, -1);
    run_txn(WR, 32'h8, 3'd4, {32'hD, 32'hC, 32'hB, 32'hA}, 16'h0, 0, 0, 0, 0, 2);
    run_txn(RD, 32'h0, 3'd0, '0, 16'hFFFF, 1, 0, 0, 0, -1);
    run_txn(RD, 32'h4, 3'd7, '0, 16'h0, 0, 1, 0, 2, -1);

    for (int k = 0; k < 40; k++) begin
      cm = $urandom_range(0, 1) ? WR : RD;
      a  = ($urandom_range(0, 4) == 0) ? 32'h20 + 4 * $urandom_range(0, 7) : 4 * $urandom_range(0, 7);
      c  = 3'($urandom_range(0, 7));
      d  = {$urandom, $urandom, $urandom, $urandom};
      n  = (c == 3'd0) ? 1 : ((c > 3'd4) ? 4 : int'(c));
      ak = -1;
      if (n > 1 && $urandom_range(0, 5) == 0) ak = $urandom_range(1, n - 1);
      run_txn(cm, a, c, d, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), ak);
    end

    // Reset in the middle of a read burst, after two words have moved.
    @(negedge clk);
    cur_cmd = RD; cur_addr = 32'h10; cur_n = 4; abort_k = -1;
    for (int i = 0; i < 4; i++) begin
      cur_be[i] = 4'h0; w_plan[i] = 0;
    end
    req_cmd = RD; req_addr = 32'h10; req_count = 3'd4; wr_be = 16'h0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_xfer_cnt", xfer_cnt, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0;
    chk("mid_rst_frame_n", bus.frame_n, 1'b1);
    chk("mid_rst_irdy_n", bus.irdy_n, 1'b1);
    chk("mid_rst_ad_oe", bus.ad_oe, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_rd_data", rd_data, 128'h0);
    repeat (10) @(negedge clk);

    run_txn(RD, 32'h10, 3'd4, '0, 16'h0, 0, 0, 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
PCI bus master that drives the FRAME#/IRDY# side of the team's PCI link. It accepts a single-beat request from local logic (command, address, up to 4 data words) and runs one burst read or write on the shared AD/CBE bus. It completes the handshake with a DEVSEL#/TRDY# target and returns read data or abort status. AD tri-stating is done at the top level as AD = ad_oe ? ad_out : 'z.

Parameters:
DATA_W, 32, AD/data word width
MAX_WORDS, 4, maximum burst length
DEVSEL_TIMEOUT, 5, rising edges after the address phase before master abort
PCI_READ, 4'b0010, memory-read command code
PCI_WRITE, 4'b0011, memory-write command code

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_cmd  in  4  PCI_READ or PCI_WRITE
req_addr  in  32  target address
req_count  in  3  words to transfer (0 is treated as 1, values >4 clip to 4)
wr_data  in  128  write words, word0 in [31:0]
wr_be  in  16  active-low byte enables, 4 per word, word0 in [3:0]
rd_data  out  128  read words, same packing
done  out  1  one-cycle completion pulse
status  out  2  00 OK, 01 master abort, 10 target abort
xfer_cnt  out  3  words actually transferred in the last transaction
frame_n  out  1  FRAME#
irdy_n  out  1  IRDY#
cbe  out  4  C/BE#
ad_out  out  32  AD drive value
ad_oe  out  1  AD output enable
ad_in  in  32  sampled AD
devsel_n  in  1  DEVSEL#
trdy_n  in  1  TRDY#

Behaviour:
- Reset (sync): state=IDLE. frame_n=1, irdy_n=1, cbe=4'hF, ad_oe=0, ad_out=0, done=0, status=00, xfer_cnt=0, rd_data=0. Reset during any state aborts the bus next cycle, with no done pulse.
- IDLE: req_ready=1. When req_valid=1 at an edge, latch cmd, addr, count, wr_data and wr_be, clear idx, and go to ADDR. Every transaction therefore starts with at least one idle bus cycle.
- ADDR (exactly 1 cycle): frame_n=0, irdy_n=1, ad_oe=1, ad_out=addr, cbe=cmd. Start the DEVSEL timer. Next state is DATA.
- DATA drives:
  - irdy_n=0 and cbe=be[idx].
  - Write: ad_oe=1 and ad_out=word[idx].
  - Read: ad_oe=0 in every DATA cycle (turnaround).
  - frame_n=0, except frame_n=1 while idx==count-1 (last data phase).
- Transfer completes at an edge with irdy_n=0, devsel_n=0 and trdy_n=0:
  - Read: rd_data[idx] <= ad_in.
  - idx and xfer_cnt increment.
  - If this was the last word: go to IDLE with frame_n=1, irdy_n=1, ad_oe=0, done=1, status=00.
- Wait states (trdy_n=1): all outputs are held unchanged.
- Master abort: devsel_n is still 1 at the DEVSEL_TIMEOUT-th edge after ADDR. Go to ABORT with status=01.
- Target abort: devsel_n returns to 1 after having been sampled 0, before the last transfer. Go to ABORT with status=10.
- ABORT (1 cycle): frame_n=1, irdy_n=0, ad_oe=0. Next state is IDLE with irdy_n=1 and done=1. Untransferred rd_data words keep their previous values.
- done is high for exactly the first IDLE cycle after completion. status and xfer_cnt hold until the next request is accepted.
- A request arriving in the same cycle as done is accepted.

Decomposition:
- pci_pkg: command codes, status codes (OK/MABORT/TABORT), state enum {IDLE, ADDR, DATA, ABORT}.
- Sub-module pci_devsel_timer: load/run/expire counter for master-abort detection.
- All other logic lives in the single FSM.

Test Plan:
- Write, addr 0x10, count 4, data 1001..1004, be 0000, against the team's PCI target model -> target memory holds 1001..1004; frame_n=1 only in the 4th data phase; done with status 00 and xfer_cnt 4.
- Read, addr 0x10, count 4, after the write -> rd_data words = 1001..1004; ad_oe=0 in every DATA cycle; status 00.
- Write, count 1, data 0xABCD -> frame_n rises in the same cycle irdy_n falls; exactly one transfer; xfer_cnt 1.
- Read, addr 0x20 (no target) -> devsel_n never 0; ABORT entered 5 edges after ADDR; done with status 01 and xfer_cnt 0.
- Target inserts 2 wait states (trdy_n=1) on word 2 of a write -> ad_out, cbe and irdy_n stable during the waits; done arrives 2 cycles later than with no waits.
- rst pulsed in DATA after 2 read words -> next cycle frame_n=1, irdy_n=1, ad_oe=0, req_ready=1; done never asserted.
